// File: rtl/inv_fo_pkg.sv
// Shared types for the slew-limited inverting driver bank.
package inv_fo_pkg;

    typedef enum logic [1:0] {
        MODE_INV  = 2'b00,
        MODE_BUF  = 2'b01,
        MODE_HOLD = 2'b10,
        MODE_CLR  = 2'b11
    } mode_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SLEW = 1'b1
    } state_e;

endpackage

// File: rtl/inv_fo_bank_slew_pick.sv
// Selects the lowest-indexed min(STEP, popcount(diff)) set bits of diff.
module slew_pick #(
    parameter int WIDTH = 8,
    parameter int STEP  = 2
) (
    input  logic [WIDTH-1:0] diff,
    output logic [WIDTH-1:0] mask
);

    int cnt;

    always_comb begin
        mask = '0;
        cnt  = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (diff[i] && (cnt < STEP)) begin
                mask[i] = 1'b1;
                cnt     = cnt + 1;
            end
        end
    end

endmodule

// File: rtl/inv_fo_bank.sv
// Inverting driver bank that walks out toward a registered target,
// toggling at most STEP lines per clock.
module inv_fo_bank
    import inv_fo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] tgt_new;

    assign diff = out_q ^ target_q;

    slew_pick #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_pick (
        .diff (diff),
        .mask (mask)
    );

    always_comb begin
        case (mode_e'(mode))
            MODE_INV:  tgt_new = ~in;
            MODE_BUF:  tgt_new = in;
            MODE_HOLD: tgt_new = out_q;
            MODE_CLR:  tgt_new = '0;
            default:   tgt_new = out_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        out_d    = out_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    target_d = tgt_new;
                    if (tgt_new != out_q) begin
                        state_d = S_SLEW;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_SLEW: begin
                out_d = out_q ^ mask;
                if (out_d == target_q) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Reset wins over any simultaneous request and discards the target.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            target_q <= '0;
            out_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            out_q    <= out_d;
            done_q   <= done_d;
        end
    end

    assign in_ready = (state_q == S_IDLE);
    assign busy     = (state_q == S_SLEW);
    assign out      = out_q;
    assign done     = done_q;

endmodule

// File: tb/tb_inv_fo_bank.sv
// Self-checking bench for inv_fo_bank at WIDTH=8, STEP=2.
module tb_inv_fo_bank;

    localparam logic [1:0] M_INV  = 2'b00;
    localparam logic [1:0] M_BUF  = 2'b01;
    localparam logic [1:0] M_HOLD = 2'b10;
    localparam logic [1:0] M_CLR  = 2'b11;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in;
    logic [1:0] mode;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];

    typedef struct {
        logic [1:0] m;
        logic [7:0] din;
        logic [7:0] fin;
    } vec_t;

    vec_t vecs[6];

    inv_fo_bank #(.WIDTH(8), .STEP(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .in       (in),
        .mode     (mode),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out      (out),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [7:0] act,
                         input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] step_model(input logic [7:0] cur,
                                              input logic [7:0] tgt);
        logic [7:0] r;
        int k;
        r = cur;
        k = 0;
        for (int i = 0; i < 8; i++) begin
            if (cur[i] != tgt[i] && k < 2) begin
                r[i] = ~r[i];
                k++;
            end
        end
        return r;
    endfunction

    task automatic push_path(input logic [7:0] from, input logic [7:0] tgt);
        logic [7:0] c;
        c = from;
        for (int n = 0; n < 8 && c != tgt; n++) begin
            c = step_model(c, tgt);
            exp_q.push_back(c);
        end
    endtask

    // Expected per-edge out values must be queued before calling.
    task automatic do_req(input string nm, input logic [1:0] m,
                          input logic [7:0] d, input bit poke);
        logic [7:0] prev;
        logic [7:0] e;
        int n;
        n = exp_q.size();
        in_valid = 1'b1;
        mode = m;
        in = d;
        tick();
        in_valid = 1'b0;
        in = 8'h5A;
        mode = M_INV;
        if (n == 0) begin
            check({nm, "_zd_done"}, {7'd0, done}, 8'd1);
            check({nm, "_zd_busy"}, {7'd0, busy}, 8'd0);
            tick();
            check({nm, "_zd_done_off"}, {7'd0, done}, 8'd0);
        end else begin
            check({nm, "_busy0"}, {7'd0, busy}, 8'd1);
            check({nm, "_rdy0"}, {7'd0, in_ready}, 8'd0);
            while (exp_q.size() > 0) begin
                if (poke) begin
                    in_valid = (exp_q.size() > 1);
                    in = 8'h00;
                    mode = M_CLR;
                end
                prev = out;
                tick();
                e = exp_q.pop_front();
                check({nm, "_out"}, out, e);
                check({nm, "_step_le2"},
                      {7'd0, ($countones(prev ^ out) <= 2)}, 8'd1);
                if (exp_q.size() > 0) begin
                    check({nm, "_busy"}, {7'd0, busy}, 8'd1);
                    check({nm, "_nodone"}, {7'd0, done}, 8'd0);
                    check({nm, "_rdy"}, {7'd0, in_ready}, 8'd0);
                end
            end
            in_valid = 1'b0;
            check({nm, "_done"}, {7'd0, done}, 8'd1);
            check({nm, "_idle"}, {7'd0, busy}, 8'd0);
            check({nm, "_rdy_end"}, {7'd0, in_ready}, 8'd1);
            tick();
            check({nm, "_done_off"}, {7'd0, done}, 8'd0);
        end
    endtask

    initial begin
        vecs[0] = '{m: M_INV,  din: 8'hF0, fin: 8'h0F};
        vecs[1] = '{m: M_BUF,  din: 8'h3C, fin: 8'h3C};
        vecs[2] = '{m: M_CLR,  din: 8'hFF, fin: 8'h00};
        vecs[3] = '{m: M_INV,  din: 8'hAA, fin: 8'h55};
        vecs[4] = '{m: M_HOLD, din: 8'h00, fin: 8'h55};
        vecs[5] = '{m: M_BUF,  din: 8'hFF, fin: 8'hFF};

        rst = 1'b1;
        in_valid = 1'b1;
        in = 8'h00;
        mode = M_INV;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_out", out, 8'h00);
            check("rst_busy", {7'd0, busy}, 8'd0);
            check("rst_done", {7'd0, done}, 8'd0);
            check("rst_rdy", {7'd0, in_ready}, 8'd1);
        end
        in_valid = 1'b0;
        rst = 1'b0;
        tick();
        check("rel_out", out, 8'h00);
        check("rel_busy", {7'd0, busy}, 8'd0);

        // Invert of zero: full distance slew.
        exp_q = '{8'h03, 8'h0F, 8'h3F, 8'hFF};
        do_req("inv00", M_INV, 8'h00, 1'b0);

        // Buffer 0x81 from 0xFF, with a competing request during the slew.
        exp_q = '{8'hF9, 8'hE1, 8'h81};
        do_req("buf81", M_BUF, 8'h81, 1'b1);
        check("buf81_final", out, 8'h81);

        // Zero-distance requests.
        do_req("hold", M_HOLD, 8'h33, 1'b0);
        check("hold_out", out, 8'h81);
        do_req("bufsame", M_BUF, 8'h81, 1'b0);

        // Back-to-back zero-distance: one done per request.
        in_valid = 1'b1;
        mode = M_HOLD;
        tick();
        check("b2b_done1", {7'd0, done}, 8'd1);
        tick();
        check("b2b_done2", {7'd0, done}, 8'd1);
        in_valid = 1'b0;
        tick();
        check("b2b_done_off", {7'd0, done}, 8'd0);
        check("b2b_out", out, 8'h81);

        // Move to 0x55, then clear.
        push_path(8'h81, 8'h55);
        do_req("to55", M_BUF, 8'h55, 1'b0);
        check("to55_final", out, 8'h55);
        exp_q = '{8'h50, 8'h00};
        do_req("clr", M_CLR, 8'hFF, 1'b0);

        // Reset in the middle of a slew.
        in_valid = 1'b1;
        mode = M_INV;
        in = 8'h00;
        tick();
        in_valid = 1'b0;
        tick();
        check("mid_o1", out, 8'h03);
        tick();
        check("mid_o2", out, 8'h0F);
        rst = 1'b1;
        in_valid = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        check("mid_rst_out", out, 8'h00);
        check("mid_rst_busy", {7'd0, busy}, 8'd0);
        check("mid_rst_done", {7'd0, done}, 8'd0);
        check("mid_rst_rdy", {7'd0, in_ready}, 8'd1);
        tick();
        check("mid_rst_done2", {7'd0, done}, 8'd0);
        check("mid_rst_out2", out, 8'h00);
        exp_q = '{8'h03, 8'h0F};
        do_req("after_rst", M_BUF, 8'h0F, 1'b0);

        for (int v = 0; v < 6; v++) begin
            push_path(out, vecs[v].fin);
            do_req($sformatf("vec%0d", v), vecs[v].m, vecs[v].din, 1'b0);
            check($sformatf("vec%0d_final", v), out, vecs[v].fin);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
